// File: rtl/disp_bcd_ctrl_pkg.sv
// Shared types and constants for the BCD display controller.
package disp_bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam int unsigned ITER     = 10;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'b1111111;
    case (hex)
      4'h0: seg_c = 7'b1000000;
      4'h1: seg_c = 7'b1111001;
      4'h2: seg_c = 7'b0100100;
      4'h3: seg_c = 7'b0110000;
      4'h4: seg_c = 7'b0011001;
      4'h5: seg_c = 7'b0010010;
      4'h6: seg_c = 7'b0000010;
      4'h7: seg_c = 7'b1111000;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0010000;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b0000011;
      4'hC: seg_c = 7'b1000110;
      4'hD: seg_c = 7'b0100001;
      4'hE: seg_c = 7'b0000110;
      4'hF: seg_c = 7'b0001110;
      default: seg_c = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/disp_bcd_ctrl.sv
// Captures a switch value, converts to BCD (double-dabble) or hex,
// and drives four 7-segment digits with optional leading-zero blanking.
module disp_bcd_ctrl
  import disp_bcd_ctrl_pkg::*;
#(
  parameter int unsigned W_BIN    = 10,
  parameter int unsigned N_DIG    = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [W_BIN-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam int unsigned W_BCD = 4 * N_DIG;
  localparam int unsigned W_CNT = 4;
  localparam logic [6:0]  SEG_HI_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  state_e           state;
  logic             mode_q;
  logic [W_BIN-1:0] bin_cap;
  logic [W_BIN-1:0] sh_bin;
  logic [W_BCD-1:0] bcd;
  logic [W_BCD-1:0] bcd_adj;
  logic [W_CNT-1:0] cnt;
  logic [3:0]       dig     [N_DIG];
  logic [6:0]       seg     [N_DIG];
  logic [6:0]       seg_out [N_DIG];
  logic [N_DIG-1:0] blank;

  // Add-3 correction on every nibble that would overflow a decimal digit
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_DIG); i++) dig[i] = mode_q ? bcd[4*i +: 4] : 4'd0;
    if (!mode_q) begin
      dig[0] = bin_cap[3:0];
      dig[1] = bin_cap[7:4];
      dig[2] = 4'(bin_cap[W_BIN-1:8]);
    end
  end

  // Digit k>=1 blanks when it and every higher digit are zero; MSD is unused in hex mode
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    blank  = '0;
    for (int k = int'(N_DIG) - 1; k >= 1; k--) begin
      any_nz   = any_nz | (dig[k] != 4'd0);
      blank[k] = BLANK_LZ && !any_nz;
    end
    if (!mode_q) blank[N_DIG-1] = 1'b1;
  end

  for (genvar g = 0; g < int'(N_DIG); g++) begin : g_dig
    hex_to_7seg u_dec (
      .hex   (dig[g]),
      .seg_c (seg[g])
    );
    assign seg_out[g] = blank[g] ? SEG_BLANK : seg[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_q  <= 1'b0;
      bin_cap <= '0;
      sh_bin  <= '0;
      bcd     <= '0;
      cnt     <= '0;
      HEX0    <= SEG_ZERO;
      HEX1    <= SEG_HI_RST;
      HEX2    <= SEG_HI_RST;
      HEX3    <= SEG_HI_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_cap <= bin_in;
            mode_q  <= mode;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          bcd    <= '0;
          sh_bin <= bin_cap;
          cnt    <= '0;
          state  <= mode_q ? SHIFT : DONE;
        end
        SHIFT: begin
          {bcd, sh_bin} <= (W_BCD + W_BIN)'({bcd_adj, sh_bin} << 1);
          cnt           <= cnt + W_CNT'(1);
          if (cnt == W_CNT'(ITER - 1)) state <= DONE;
        end
        DONE: begin
          HEX0  <= seg_out[0];
          HEX1  <= seg_out[1];
          HEX2  <= seg_out[2];
          HEX3  <= seg_out[3];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_bcd_ctrl.sv
// Self-checking bench for disp_bcd_ctrl: directed table, random vs. arithmetic model, corner sequences.
module tb_disp_bcd_ctrl;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] Z  = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SE = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] bin_in = '0;
  logic       busy, done, busy2, done2;
  logic [6:0] h0, h1, h2, h3, z0, z1, z2, z3;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  disp_bcd_ctrl #(.W_BIN(10), .N_DIG(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bin_in(bin_in),
    .busy(busy), .done(done), .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3)
  );

  disp_bcd_ctrl #(.W_BIN(10), .N_DIG(4), .BLANK_LZ(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bin_in(bin_in),
    .busy(busy2), .done(done2), .HEX0(z0), .HEX1(z1), .HEX2(z2), .HEX3(z3)
  );

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Display predicted from positional arithmetic: digit k = (v / base^k) % base
  function automatic logic [27:0] model(input bit m, input int v, input bit lz);
    logic [27:0] r;
    int base, p, d;
    bit blk;
    base = m ? 10 : 16;
    p = 1;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      d   = (v / p) % base;
      blk = (k > 0) && ((lz && v < p) || (!m && k == 3));
      r[7*k +: 7] = blk ? B : seg_of(d);
      p = p * base;
    end
    return r;
  endfunction

  function automatic logic [27:0] disp1();
    return {h3, h2, h1, h0};
  endfunction

  function automatic logic [27:0] disp2();
    return {z3, z2, z1, z0};
  endfunction

  // Runs one conversion; reports latency, final displays and checks hold/busy/done shape
  task automatic run_conv(input string name, input bit m, input int v,
                          output int lat, output logic [27:0] r1, output logic [27:0] r2);
    logic [27:0] prev;
    bit held, busy_ok;
    prev = disp1();
    held = 1'b1;
    busy_ok = 1'b1;
    lat = 0;
    @(negedge clk);
    start = 1'b1; mode = m; bin_in = 10'(v);
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom_range(0, 1)); bin_in = 10'($urandom);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (done) lat = n;
      else begin
        if (disp1() !== prev) held = 1'b0;
        if (!busy) busy_ok = 1'b0;
      end
    end
    r1 = disp1();
    r2 = disp2();
    check({name, " hold+busy"}, 28'({held, busy_ok}), 28'b11);
    @(posedge clk); #1;
    check({name, " done/busy drop"}, 28'({done, done2, busy, busy2}), 28'd0);
  endtask

  typedef struct {
    bit          m;
    int          v;
    logic [27:0] exp_lz;
    logic [27:0] exp_nz;
  } vec_t;

  initial begin
    vec_t        tab [7];
    int          lat, dcount;
    logic [27:0] r1, r2;
    bit          m;
    int          v;

    tab[0] = '{1'b1, 1023,   {S1, Z, S2, S3}, {S1, Z, S2, S3}};
    tab[1] = '{1'b1, 0,      {B, B, B, Z},    {Z, Z, Z, Z}};
    tab[2] = '{1'b0, 'h3A5,  {B, S3, SA, S5}, {B, S3, SA, S5}};
    tab[3] = '{1'b1, 42,     {B, B, S4, S2},  {Z, Z, S4, S2}};
    tab[4] = '{1'b0, 'h005,  {B, B, B, S5},   {B, Z, Z, S5}};
    tab[5] = '{1'b1, 100,    {B, S1, Z, Z},   {Z, S1, Z, Z}};
    tab[6] = '{1'b0, 'h3E8,  {B, S3, SE, S8}, {B, S3, SE, S8}};

    // Reset asserted asynchronously before any clock edge matters
    #5 rst_n = 1'b0;
    #1;
    check("reset disp", disp1(), {B, B, B, Z});
    check("reset disp nz", disp2(), {Z, Z, Z, Z});
    check("reset busy/done", 28'({busy, done, busy2, done2}), 28'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle disp", disp1(), {B, B, B, Z});
    check("idle busy/done", 28'({busy, done}), 28'd0);

    foreach (tab[i]) begin
      run_conv($sformatf("vec%0d", i), tab[i].m, tab[i].v, lat, r1, r2);
      check($sformatf("vec%0d latency", i), 28'(lat), 28'(tab[i].m ? 12 : 2));
      check($sformatf("vec%0d disp", i), r1, tab[i].exp_lz);
      check($sformatf("vec%0d disp nz", i), r2, tab[i].exp_nz);
    end

    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom_range(0, 1));
      v = int'($urandom_range(0, 1023));
      run_conv($sformatf("rnd%0d", i), m, v, lat, r1, r2);
      check($sformatf("rnd%0d latency", i), 28'(lat), 28'(m ? 12 : 2));
      check($sformatf("rnd%0d disp v=%0d m=%0d", i, v, m), r1, model(m, v, 1'b1));
      check($sformatf("rnd%0d disp nz", i), r2, model(m, v, 1'b0));
    end

    // Starts while busy and in the done cycle are dropped
    dcount = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; bin_in = 10'd5;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start  = (n == 4) || (n == 12);
      bin_in = (n == 4) ? 10'd999 : 10'd7;
      @(posedge clk); #1;
      if (done) dcount++;
    end
    start = 1'b0;
    check("ignored start done count", 28'(dcount), 28'd1);
    check("ignored start disp", disp1(), {B, B, B, S5});
    check("ignored start idle", 28'(busy), 28'd0);

    // Reset in the middle of a decimal conversion
    @(negedge clk);
    start = 1'b1; mode = 1'b1; bin_in = 10'd512;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset disp", disp1(), {B, B, B, Z});
    check("midreset busy/done", 28'({busy, done}), 28'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("midreset no done", 28'(dcount), 28'd0);
    check("midreset disp held", disp1(), {B, B, B, Z});
    run_conv("after reset", 1'b1, 42, lat, r1, r2);
    check("after reset latency", 28'(lat), 28'd12);
    check("after reset disp", r1, {B, B, S4, S2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_bcd_ctrl.md
Name: disp_bcd_ctrl

Overview:
Sequencing controller for the board's 7-segment display path. It captures a 10-bit switch value on a start pulse and converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine, or passes it straight through in hex mode. It then drives four hex_to_7seg decoders with optional leading-zero blanking. It sits between the switch/key inputs and HEX0..HEX3, and replaces direct SW-to-decoder wiring in later lab tops.

Parameters:
W_BIN, 10, binary input width (only 10 supported; sizes digit count and shift count)
N_DIG, 4, number of display digits (ceil of log10(2^W_BIN) = 4)
BLANK_LZ, 1, 1 = blank leading zero digits, 0 = show all digits

Ports:
clk  in  1  system clock (50 MHz board clock)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to capture bin_in/mode; ignored unless idle
mode  in  1  0 = hex display, 1 = decimal (BCD) display
bin_in  in  10  value to display (normally SW[9:0])
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when display registers update
HEX0  out  7  digit 0 (LSD) segments, active-low, {g,f,e,d,c,b,a}
HEX1  out  7  digit 1 segments
HEX2  out  7  digit 2 segments
HEX3  out  7  digit 3 (MSD) segments

Behaviour:
- Reset is asynchronous. While rst_n is low: state IDLE, busy=0, done=0, digit registers=0, HEX0=7'b1000000 ('0'), HEX1..HEX3=7'b1111111 (blank). With BLANK_LZ=0, HEX1..HEX3 also show '0'.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: when start=1, capture bin_in and mode, go to LOAD. busy rises on the next edge.
- LOAD: clear the 16-bit BCD scratch register and load the shift register with the captured value. Clear the iteration counter to 0. Go to SHIFT if mode=1, otherwise to DONE.
- SHIFT: each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd, bin} left by 1. Increment the counter. After 10 iterations (count 9 -> exit), go to DONE.
- DONE: load the display digit registers and compute the blank mask. Assert done for exactly this cycle. Return to IDLE. busy drops on the following edge.
- Hex mode digits: d0=bin[3:0], d1=bin[7:4], d2={2'b00,bin[9:8]}, d3 always blank.
- Latency, counted from the start sample edge: hex mode gives done 2 cycles later; decimal mode gives done 12 cycles later.
- Blanking (BLANK_LZ=1): digit k is blank if it and all higher digits are zero, for k>=1. HEX0 is never blanked. Blank drives 7'b1111111.
- HEX outputs change only on the DONE edge. The previous value is held for the whole conversion, so there is no flicker.
- start while busy: ignored, not queued. start in the same cycle as done: ignored, because the FSM is not yet in IDLE.
- bin_in/mode changes after capture have no effect on the running conversion.
- Reset mid-conversion: the operation is aborted immediately and the reset display values apply.

Decomposition:
- Shared package: state encoding, segment constants SEG_BLANK=7'b1111111 and SEG_ZERO=7'b1000000, and ITER constant = W_BIN.
- Sub-modules: four instances of the existing hex_to_7seg decoder, with a blank override mux after each. No new sub-module is needed; the double-dabble step stays inline.

Test Plan:
- Reset release with no start -> HEX0=1000000, HEX1..3=1111111, busy=0, done=0.
- mode=1, bin_in=1023, start pulse -> busy for 12 cycles; done pulses at +12; HEX3=1111001('1'), HEX2=1000000('0'), HEX1=0100100('2'), HEX0=0110000('3').
- mode=1, bin_in=0 -> done at +12; HEX0='0' (1000000), HEX1..3 blank. Repeat with BLANK_LZ=0 -> all four show '0'.
- mode=0, bin_in=10'h3A5 -> done at +2; HEX2=0110000('3'), HEX1=0001000('A'), HEX0=0010010('5'), HEX3 blank.
- Decimal start with bin_in=5, then a second start with bin_in=999 at cycle +4 -> second start ignored; result shows 5 (HEX0=0010010, others blank), and exactly one done pulse.
- Decimal start with bin_in=512, rst_n low at cycle +6 for 1 cycle -> immediate reset display, busy=0, no done pulse; a following start with bin_in=42 gives HEX1=0011001('4'), HEX0=0100100('2').
